// File: rtl/memshare_baseaddr_sched.sv
// memshare_baseaddr_sched: producer of MSGPASS base addresses for the
// memShare rebase stage.
// Holds a programmable cfg table. On start it copies the cfg table into a
// working table and walks a select through every entry once per layer.
// Between layers every working entry is advanced by a stride.
// Ports:
//   sys_clk, rstn             clock, synchronous active-low reset
//   cfg_we_i/idx_i/addr_i     cfg table write (accepted only in IDLE)
//   start_i, layer_stride_i   run request and per-layer increment
//   baseAddr_aggregation_o    working table, entry i at [i*W +: W]
//   baseAddr_sel_o, sel_valid_o, sel_ready_i   select handshake
//   layer_idx_o, busy_o, done_o                run status
module memshare_baseaddr_sched #(
  parameter int ADDR_WIDTH  = 8,
  parameter int BASE_NUM    = 4,
  parameter int LAYER_NUM   = 4,
  parameter int SEL_WIDTH   = $clog2(BASE_NUM),
  parameter int LAYER_WIDTH = (LAYER_NUM > 1) ? $clog2(LAYER_NUM) : 1
) (
  input  logic                           sys_clk,
  input  logic                           rstn,
  input  logic                           cfg_we_i,
  input  logic [SEL_WIDTH-1:0]           cfg_idx_i,
  input  logic [ADDR_WIDTH-1:0]          cfg_addr_i,
  input  logic                           start_i,
  input  logic [ADDR_WIDTH-1:0]          layer_stride_i,
  output logic [BASE_NUM*ADDR_WIDTH-1:0] baseAddr_aggregation_o,
  output logic [SEL_WIDTH-1:0]           baseAddr_sel_o,
  output logic                           sel_valid_o,
  input  logic                           sel_ready_i,
  output logic [LAYER_WIDTH-1:0]         layer_idx_o,
  output logic                           busy_o,
  output logic                           done_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [BASE_NUM-1:0][ADDR_WIDTH-1:0] cfg_q;
  logic [BASE_NUM-1:0][ADDR_WIDTH-1:0] work_q;
  logic [ADDR_WIDTH-1:0]               stride_q;
  logic [SEL_WIDTH-1:0]                sel_q;
  logic [LAYER_WIDTH-1:0]              layer_q;

  logic last_sel;
  logic last_layer;
  logic hs;

  assign last_sel   = (sel_q == SEL_WIDTH'(BASE_NUM - 1));
  assign last_layer = (layer_q == LAYER_WIDTH'(LAYER_NUM - 1));
  assign hs         = (state_q == ISSUE) && sel_ready_i;

  always_ff @(posedge sys_clk) begin
    if (!rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sel_valid_o = 1'b0;
    busy_o      = 1'b1;
    done_o      = 1'b0;
    case (state_q)
      IDLE: begin
        busy_o = 1'b0;
        if (start_i) begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        sel_valid_o = 1'b1;
        if (sel_ready_i && last_sel && last_layer) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The copy on start reads cfg_q before any same-cycle write lands,
  // so a simultaneous write only affects the following run.
  always_ff @(posedge sys_clk) begin
    if (!rstn) begin
      cfg_q    <= '0;
      work_q   <= '0;
      stride_q <= '0;
      sel_q    <= '0;
      layer_q  <= '0;
    end else begin
      if (cfg_we_i && (state_q == IDLE)) begin
        cfg_q[cfg_idx_i] <= cfg_addr_i;
      end
      if ((state_q == IDLE) && start_i) begin
        work_q   <= cfg_q;
        stride_q <= layer_stride_i;
        sel_q    <= '0;
        layer_q  <= '0;
      end else if (hs) begin
        if (!last_sel) begin
          sel_q <= sel_q + SEL_WIDTH'(1);
        end else if (!last_layer) begin
          // entries, select and layer move together on one edge
          sel_q   <= '0;
          layer_q <= layer_q + LAYER_WIDTH'(1);
          for (int i = 0; i < BASE_NUM; i++) begin
            work_q[i] <= work_q[i] + stride_q;
          end
        end
      end
    end
  end

  assign baseAddr_aggregation_o = work_q;
  assign baseAddr_sel_o         = sel_q;
  assign layer_idx_o            = layer_q;

endmodule

// File: doc/memshare_baseaddr_sched.md
Name: memshare_baseaddr_sched

Overview:
Producer side of the message-pass base-address rebase interface. It holds a programmable table of MSGPASS base addresses and drives the aggregated base-address bus plus a per-request select, sequenced per layer. Between layers it advances every base address by a layer stride. It sits upstream of the SCU.memShare() rebase stage and pairs with it. The rebase stage registers the aggregation bus and the select together, so this block always changes them on the same edge.

Parameters:
- ADDR_WIDTH, 8, width of one base address (= MSGPASS_RD_ADDR_WIDTH).
- BASE_NUM, 4, number of base-address entries (= MSGPASS_BASEADDR_NUM); power of two, ≥2.
- LAYER_NUM, 4, number of layers iterated per run; ≥1.
- SEL_WIDTH, $clog2(BASE_NUM), select width.
- LAYER_WIDTH, max(1,$clog2(LAYER_NUM)), layer index width.

Ports:
- sys_clk  in  1  clock.
- rstn  in  1  reset, synchronous, active-low; clock sys_clk.
- cfg_we_i  in  1  write strobe for the configuration table.
- cfg_idx_i  in  SEL_WIDTH  table entry index.
- cfg_addr_i  in  ADDR_WIDTH  base-address value written.
- start_i  in  1  run request, single-cycle pulse.
- layer_stride_i  in  ADDR_WIDTH  per-layer increment, sampled on accepted start.
- baseAddr_aggregation_o  out  BASE_NUM*ADDR_WIDTH  working table; entry i at bits [(i+1)*ADDR_WIDTH-1 : i*ADDR_WIDTH].
- baseAddr_sel_o  out  SEL_WIDTH  current select.
- sel_valid_o  out  1  select valid.
- sel_ready_i  in  1  consumer accepts select.
- layer_idx_o  out  LAYER_WIDTH  current layer.
- busy_o  out  1  high in any state except IDLE.
- done_o  out  1  single-cycle end-of-run pulse.

Behaviour:
- Storage: cfg table (BASE_NUM×ADDR_WIDTH) and working table (same size). baseAddr_aggregation_o is the working table, driven straight from registers.
- Reset values: all outputs 0, both tables 0, stride register 0, state IDLE. Reset has priority over every other input, including in the middle of a run: the block returns to IDLE in the next cycle with sel_valid_o=0 and no done_o.
- Config writes: when cfg_we_i=1 and state=IDLE, cfg_table[cfg_idx_i] <= cfg_addr_i. Writes are ignored when state≠IDLE. The working table is not affected by config writes.
- FSM states are IDLE, ISSUE, DONE.
- IDLE:
  - start_i=1 → working table <= cfg table, stride register <= layer_stride_i, sel=0, layer=0, next state ISSUE.
  - If cfg_we_i and start_i are both high in the same cycle, the write lands in the cfg table but the copy uses the pre-write value.
  - In IDLE, sel_valid_o=0 and the working table holds its last values.
- ISSUE:
  - sel_valid_o=1.
  - A handshake is sel_valid_o & sel_ready_i at a clock edge.
  - While sel_ready_i=0: baseAddr_sel_o, layer_idx_o and the working table are frozen.
  - On a handshake with sel<BASE_NUM-1: sel <= sel+1.
  - On a handshake with sel=BASE_NUM-1 and layer<LAYER_NUM-1: sel <= 0, layer <= layer+1, and every working entry <= entry + stride, modulo 2^ADDR_WIDTH (carry discarded). Entries, select and layer all update on the same edge.
  - On a handshake with sel=BASE_NUM-1 and layer=LAYER_NUM-1: next state DONE. The working table is not advanced after the final layer.
- DONE: done_o=1 and sel_valid_o=0 for exactly one cycle, then IDLE.
- start_i is ignored in ISSUE and DONE. A start pulse in DONE is not queued.
- Latency:
  - First valid appears 1 cycle after the start edge.
  - With sel_ready_i held at 1, one select is issued per cycle: BASE_NUM*LAYER_NUM issue cycles, then the DONE cycle.
  - done_o asserts BASE_NUM*LAYER_NUM+1 cycles after the start edge.
- Invariant: baseAddr_sel_o < BASE_NUM at all times. With LAYER_NUM=1, no stride add occurs.

Test Plan:
- Nominal run. Setup: ADDR_WIDTH=8, BASE_NUM=4, LAYER_NUM=2. Write table {0x10,0x20,0x30,0x40}, stride 0x08, sel_ready_i=1. Required response:
  - sel sequence 0,1,2,3 with aggregation {0x40,0x30,0x20,0x10} (MSB→LSB) and layer 0;
  - then sel 0,1,2,3 with {0x48,0x38,0x28,0x18} and layer 1;
  - done_o exactly 9 cycles after the start edge.
- Wrap-around: entry0=0xFC, stride 0x08 → layer-1 entry0=0x04, with no effect on the neighbouring entries.
- Backpressure: hold sel_ready_i=0 for 3 cycles at sel=2 of layer 0 → sel, layer and aggregation stay constant and sel_valid_o stays 1. After release, the run completes with done_o 3 cycles later than the nominal run.
- Busy-time inputs: during ISSUE, pulse start_i and write cfg_idx=1, cfg_addr=0xAA → the run is unaffected and cfg entry1 is still 0x20. A second run started afterwards reproduces the nominal sequence, confirming the cfg table is unchanged by the first run's stride adds.
- Reset mid-run: assert rstn=0 at layer 1, sel=1 → the next cycle shows all outputs 0, busy_o=0, no done_o, and both tables zeroed.
- Simultaneous write and start in IDLE: cfg_we_i with cfg_idx=0, cfg_addr=0x55 in the same cycle as start_i → layer-0 entry0 uses the old value 0x10. The following run uses 0x55.
